battle_turn_controller: RTL and testbench

- Turn sequencer that sits directly upstream of the damage datapath (move decode, damage register, HP register, decrement control, white-bar draw).
- Accepts a player move request and latches the move code, then steps the datapath enables in the required order.
- Waits for the datapath done handshakes and samples game_over. It then either closes the turn or locks into battle-over.
- Adds a per-phase watchdog and a post-turn cooldown so that input bounce cannot start back-to-back turns.

---
 rtl/battle_turn_controller_pkg.sv | 25 ++
 rtl/battle_turn_controller_if.sv | 32 +++
 rtl/battle_turn_controller_phase_watchdog.sv | 28 ++
 rtl/battle_turn_controller.sv | 142 ++++++++++++++
 tb/tb_battle_turn_controller.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/battle_turn_controller_pkg.sv
// Shared constants for the battle turn sequencer: state encoding, move codes
// and the legal-move check used at request acceptance.
package battle_turn_controller_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE      = 4'd0;
   localparam state_t S_LOAD      = 4'd1;
   localparam state_t S_CALC      = 4'd2;
   localparam state_t S_WRITE     = 4'd3;
   localparam state_t S_DECREMENT = 4'd4;
   localparam state_t S_DRAW      = 4'd5;
   localparam state_t S_CHECK     = 4'd6;
   localparam state_t S_COOL      = 4'd7;
   localparam state_t S_OVER      = 4'd8;

   localparam logic [2:0] MOVE_QA = 3'b001;
   localparam logic [2:0] MOVE_TB = 3'b010;
   localparam logic [2:0] MOVE_VT = 3'b100;

   function automatic logic move_is_legal(input logic [2:0] sel);
      return (sel == MOVE_QA) || (sel == MOVE_TB) || (sel == MOVE_VT);
   endfunction

endpackage

// File: rtl/battle_turn_controller_if.sv
// Request and datapath-control bundle between the turn sequencer (master)
// and the move source / damage datapath (slave).
interface battle_turn_controller_if;

   // move_valid is a one-cycle strobe with no ready: it is consumed only in
   // IDLE with a legal one-hot move_sel, otherwise dropped. The done lines are
   // levels that stay high until the matching enable falls.
   logic [2:0] move_sel;
   logic       move_valid;
   logic       done_decrement;
   logic       done_damage;
   logic       game_over;
   logic [2:0] move_code;
   logic       enable_DMG_reg;
   logic       enable_DMG_calc;
   logic       enable_HP_calc;
   logic       enable_decrement_control;
   logic       enable_draw_decrease;

   modport master (
      input  move_sel, move_valid, done_decrement, done_damage, game_over,
      output move_code, enable_DMG_reg, enable_DMG_calc, enable_HP_calc,
             enable_decrement_control, enable_draw_decrease
   );

   modport slave (
      output move_sel, move_valid, done_decrement, done_damage, game_over,
      input  move_code, enable_DMG_reg, enable_DMG_calc, enable_HP_calc,
             enable_decrement_control, enable_draw_decrease
   );

endinterface

// File: rtl/battle_turn_controller_phase_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// expiry while sitting on the last allowed cycle.
module battle_turn_controller_phase_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/battle_turn_controller.sv
// Turn sequencer: latches a move, steps the damage datapath enables in order,
// then closes the turn with a cooldown or locks into battle-over.
module battle_turn_controller
   import battle_turn_controller_pkg::*;
#(
   parameter int COOLDOWN_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int TURN_W          = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   battle_turn_controller_if.master bus,
   output logic                  busy,
   output logic                  turn_done,
   output logic                  battle_over,
   output logic                  fault,
   output logic [TURN_W-1:0]     turn_count,
   output state_t                state_dbg
);

   localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      move_code_q;
   logic [CD_W-1:0] cool_cnt;
   logic            wd_clear;
   logic            wd_enable;
   logic            wd_expired;
   logic            fault_set;

   // The watchdog restarts on entry to DECREMENT and again on entry to DRAW.
   assign wd_clear  = (state == S_WRITE) ||
                      ((state == S_DECREMENT) && bus.done_decrement);
   assign wd_enable = (state == S_DECREMENT) || (state == S_DRAW);

   battle_turn_controller_phase_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // A done seen on the expiry cycle wins, so fault needs the done to be low.
   assign fault_set = ((state == S_DECREMENT) && !bus.done_decrement && wd_expired) ||
                      ((state == S_DRAW) && !bus.done_damage && wd_expired);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.move_valid && move_is_legal(bus.move_sel) && !battle_over && !fault) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD:  state_nxt = S_CALC;
         S_CALC:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_DECREMENT;
         S_DECREMENT: begin
            if (bus.done_decrement) begin
               state_nxt = S_DRAW;
            end else if (wd_expired) begin
               state_nxt = S_IDLE;
            end
         end
         S_DRAW: begin
            if (bus.done_damage) begin
               state_nxt = S_CHECK;
            end else if (wd_expired) begin
               state_nxt = S_IDLE;
            end
         end
         S_CHECK: state_nxt = bus.game_over ? S_OVER : S_COOL;
         S_COOL: begin
            if (cool_cnt == '0) begin
               state_nxt = S_IDLE;
            end
         end
         S_OVER:  state_nxt = S_OVER;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_IDLE;
         move_code_q <= '0;
         cool_cnt    <= '0;
         turn_done   <= 1'b0;
         battle_over <= 1'b0;
         fault       <= 1'b0;
         turn_count  <= '0;
      end else begin
         state     <= state_nxt;
         turn_done <= 1'b0;
         if ((state == S_IDLE) && (state_nxt == S_LOAD)) begin
            move_code_q <= bus.move_sel;
         end
         if (fault_set) begin
            fault <= 1'b1;
         end
         if (state == S_CHECK) begin
            cool_cnt <= CD_LOAD;
            if (bus.game_over) begin
               battle_over <= 1'b1;
            end else begin
               turn_done <= 1'b1;
               if (turn_count != {TURN_W{1'b1}}) begin
                  turn_count <= turn_count + 1'b1;
               end
            end
         end else if ((state == S_COOL) && (cool_cnt != '0)) begin
            cool_cnt <= cool_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      bus.enable_DMG_reg           = 1'b0;
      bus.enable_DMG_calc          = 1'b0;
      bus.enable_HP_calc           = 1'b0;
      bus.enable_decrement_control = 1'b0;
      bus.enable_draw_decrease     = 1'b0;
      case (state)
         S_LOAD:      bus.enable_DMG_reg           = 1'b1;
         S_CALC:      bus.enable_DMG_calc          = 1'b1;
         S_WRITE:     bus.enable_HP_calc           = 1'b1;
         S_DECREMENT: bus.enable_decrement_control = 1'b1;
         S_DRAW:      bus.enable_draw_decrease     = 1'b1;
         default:     ;
      endcase
   end

   assign bus.move_code = move_code_q;
   assign busy          = (state != S_IDLE);
   assign state_dbg     = state;

endmodule

// File: tb/tb_battle_turn_controller.sv
// Bench for battle_turn_controller: a behavioural datapath with adjustable
// done latency and an HP model, plus a per-cycle expected-output queue.
module tb_battle_turn_controller;
   import battle_turn_controller_pkg::*;

   localparam int COOL_N = 8;
   localparam int TMO_N  = 16;
   localparam int TW     = 3;
   localparam int CNT_MAX = (1 << TW) - 1;

   localparam logic [8:0] O_FAULT = 9'h100;
   localparam logic [8:0] O_OVER  = 9'h080;
   localparam logic [8:0] O_BUSY  = 9'h040;
   localparam logic [8:0] O_TD    = 9'h020;
   localparam logic [8:0] O_REG   = 9'h010;
   localparam logic [8:0] O_CALC  = 9'h008;
   localparam logic [8:0] O_HP    = 9'h004;
   localparam logic [8:0] O_DEC   = 9'h002;
   localparam logic [8:0] O_DRAW  = 9'h001;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   battle_turn_controller_if dp ();
   logic          busy, turn_done, battle_over, fault;
   logic [TW-1:0] turn_count;
   state_t        state_dbg;

   battle_turn_controller #(
      .COOLDOWN_CYCLES (COOL_N),
      .TIMEOUT_CYCLES  (TMO_N),
      .TURN_W          (TW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (dp),
      .busy        (busy),
      .turn_done   (turn_done),
      .battle_over (battle_over),
      .fault       (fault),
      .turn_count  (turn_count),
      .state_dbg   (state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // datapath model controls
   int   hp_start = 255;
   int   dec_lat  = 3;
   int   draw_lat = 3;
   logic dec_hold = 1'b0;
   int   hp = 255;
   int   dec_age = 0;
   int   draw_age = 0;

   // reference model state
   logic [8:0] exp_q[$];
   int exp_count = 0;
   int ref_hp    = 255;
   int turn_no   = 0;

   function automatic int dmg_of(input logic [2:0] code);
      case (code)
         MOVE_QA: return 5;
         MOVE_TB: return 10;
         MOVE_VT: return 20;
         default: return 0;
      endcase
   endfunction

   function automatic logic [8:0] obs();
      return {fault, battle_over, busy, turn_done, dp.enable_DMG_reg, dp.enable_DMG_calc,
              dp.enable_HP_calc, dp.enable_decrement_control, dp.enable_draw_decrease};
   endfunction

   // Datapath: each done rises once its enable has been high for the chosen
   // latency; HP drops and game_over registers during the calc enable.
   always @(negedge clock) begin
      if (!reset) begin
         hp       = hp_start;
         dec_age  = 0;
         draw_age = 0;
      end else begin
         dec_age  = dp.enable_decrement_control ? dec_age + 1 : 0;
         draw_age = dp.enable_draw_decrease ? draw_age + 1 : 0;
         if (dp.enable_DMG_calc) begin
            hp = (hp > dmg_of(dp.move_code)) ? hp - dmg_of(dp.move_code) : 0;
         end
      end
      dp.done_decrement = !dec_hold && (dec_age > dec_lat);
      dp.done_damage    = draw_age > draw_lat;
      dp.game_over      = (hp == 0);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int start_hp);
      hp_start = start_hp;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      exp_count = 0;
      ref_hp = start_hp;
   endtask

   // One full turn: build the expected per-cycle outputs from the turn rules,
   // then issue the request and compare every cycle.
   task automatic run_turn(input logic [2:0] sel, input int ld, input int lw, input bit bounce);
      logic [2:0] prev_code;
      bit over;
      int td_idx;
      dec_lat  = ld;
      draw_lat = lw;
      ref_hp = (ref_hp > dmg_of(sel)) ? ref_hp - dmg_of(sel) : 0;
      over = (ref_hp == 0);
      exp_q.delete();
      exp_q.push_back(O_BUSY | O_REG);
      exp_q.push_back(O_BUSY | O_CALC);
      exp_q.push_back(O_BUSY | O_HP);
      for (int i = 0; i <= ld; i++) exp_q.push_back(O_BUSY | O_DEC);
      for (int i = 0; i <= lw; i++) exp_q.push_back(O_BUSY | O_DRAW);
      exp_q.push_back(O_BUSY);
      td_idx = exp_q.size();
      if (over) begin
         for (int i = 0; i < 3; i++) exp_q.push_back(O_BUSY | O_OVER);
      end else begin
         exp_q.push_back(O_BUSY | O_TD);
         for (int i = 1; i < COOL_N; i++) exp_q.push_back(O_BUSY);
         exp_q.push_back(9'h000);
         exp_q.push_back(9'h000);
      end
      prev_code = sel;
      dp.move_sel = sel;
      dp.move_valid = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clock);
         check($sformatf("turn%0d_cyc%0d", turn_no, i), 16'(obs()), 16'(exp_q[i]));
         dp.move_valid = bounce && ((i == 3) || (i == td_idx));
         dp.move_sel = dp.move_valid ? ((sel == MOVE_QA) ? MOVE_TB : MOVE_QA) : sel;
      end
      if (!over && exp_count < CNT_MAX) exp_count++;
      check($sformatf("turn%0d_count", turn_no), 16'(turn_count), 16'(exp_count));
      check($sformatf("turn%0d_code", turn_no), 16'(dp.move_code), 16'(prev_code));
      turn_no++;
   endtask

   initial begin
      int found;
      logic [2:0] rsel;
      dp.move_sel = 3'b000;
      dp.move_valid = 1'b0;

      // reset state
      do_reset(255);
      @(negedge clock);
      check("rst_outputs", 16'(obs()), 16'h0);
      check("rst_code", 16'(dp.move_code), 16'h0);
      check("rst_count", 16'(turn_count), 16'h0);
      check("rst_state", 16'(state_dbg), 16'(S_IDLE));

      // thunderbolt, 3-cycle done latency
      run_turn(MOVE_TB, 3, 3, 1'b0);

      // illegal codes are dropped
      dp.move_sel = 3'b011;
      dp.move_valid = 1'b1;
      @(negedge clock);
      check("illegal_011", 16'(obs()), 16'h0);
      dp.move_sel = 3'b000;
      @(negedge clock);
      dp.move_valid = 1'b0;
      check("illegal_000", 16'(obs()), 16'h0);
      check("illegal_code", 16'(dp.move_code), 16'(MOVE_TB));
      @(negedge clock);
      check("illegal_idle", 16'(obs()), 16'h0);

      // requests during DECREMENT and COOL are ignored
      run_turn(MOVE_VT, 4, 2, 1'b1);

      // random turns; includes done on the watchdog-expiry cycle and count saturation
      run_turn(MOVE_QA, TMO_N - 1, TMO_N - 1, 1'b0);
      run_turn(MOVE_TB, 0, 0, 1'b0);
      for (int t = 0; t < 5; t++) begin
         rsel = ($urandom_range(0, 1) == 0) ? MOVE_QA : MOVE_TB;
         run_turn(rsel, $urandom_range(0, TMO_N - 1), $urandom_range(0, TMO_N - 1), 1'b0);
      end

      // watchdog timeout in DECREMENT
      dec_hold = 1'b1;
      exp_q.delete();
      exp_q.push_back(O_BUSY | O_REG);
      exp_q.push_back(O_BUSY | O_CALC);
      exp_q.push_back(O_BUSY | O_HP);
      for (int i = 0; i < TMO_N; i++) exp_q.push_back(O_BUSY | O_DEC);
      exp_q.push_back(O_FAULT);
      dp.move_sel = MOVE_TB;
      dp.move_valid = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clock);
         dp.move_valid = 1'b0;
         check($sformatf("tmo_cyc%0d", i), 16'(obs()), 16'(exp_q[i]));
      end
      check("tmo_count", 16'(turn_count), 16'(exp_count));
      dec_hold = 1'b0;
      dp.move_sel = MOVE_QA;
      dp.move_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         dp.move_valid = 1'b0;
         check($sformatf("tmo_reject%0d", i), 16'(obs()), 16'(O_FAULT));
      end

      // reset mid-DRAW, then a normal turn
      do_reset(255);
      dp.move_sel = MOVE_TB;
      dp.move_valid = 1'b1;
      dec_lat = 2;
      draw_lat = 10;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         @(negedge clock);
         dp.move_valid = 1'b0;
         if (dp.enable_draw_decrease) found = 1;
      end
      check("reach_draw", 16'(found), 16'h1);
      reset = 1'b0;
      @(negedge clock);
      check("mid_rst_outputs", 16'(obs()), 16'h0);
      check("mid_rst_code", 16'(dp.move_code), 16'h0);
      check("mid_rst_count", 16'(turn_count), 16'h0);
      reset = 1'b1;
      exp_count = 0;
      ref_hp = 255;
      @(negedge clock);
      run_turn(MOVE_QA, 1, 2, 1'b0);

      // five volt tackles from 82 HP end the battle
      do_reset(82);
      for (int t = 0; t < 5; t++) begin
         run_turn(MOVE_VT, $urandom_range(0, 5), $urandom_range(0, 5), 1'b0);
      end
      check("over_count", 16'(turn_count), 16'd4);
      dp.move_sel = MOVE_VT;
      dp.move_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         dp.move_valid = 1'b0;
         check($sformatf("over_hold%0d", i), 16'(obs()), 16'(O_BUSY | O_OVER));
      end
      check("over_count_after", 16'(turn_count), 16'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: observed no completion expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
